// File: rtl/tanque_resposta.sv
// Tank plant model: turns the controller's actuator command word into level,
// heat and overflow-alarm sensor outputs that close the control loop.
module tanque_resposta #(
    parameter int FILL_DIV  = 4,
    parameter int DRAIN_DIV = 2,
    parameter int LOW_TH    = 4,
    parameter int HIGH_TH   = 12,
    parameter int HEAT_CYC  = 8,
    parameter int OVF_CYC   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] cmd,
    output logic       echeio,
    output logic       sa,
    output logic       se,
    output logic       temp,
    output logic [3:0] nivel,
    output logic       alarme
);

    localparam int MAX_DIV = (FILL_DIV > DRAIN_DIV) ? FILL_DIV : DRAIN_DIV;
    localparam int CW      = $clog2(MAX_DIV + 1);
    localparam int OW      = $clog2(OVF_CYC + 1);

    localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_DIV - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_DIV - 1);
    localparam logic [OW-1:0] OVF_LIM    = OW'(OVF_CYC);
    localparam logic [3:0]    LOW_L      = 4'(LOW_TH);
    localparam logic [3:0]    HIGH_L     = 4'(HIGH_TH);
    localparam logic [3:0]    HEAT_L     = 4'(HEAT_CYC);

    typedef enum logic [1:0] {
        REPOUSO,
        ENCHENDO,
        ESVAZIANDO,
        FALHA
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rate_q,  rate_d;
    logic [3:0]    nivel_q, nivel_d;
    logic [OW-1:0] ovf_q,   ovf_d;
    logic [3:0]    heat_q,  heat_d;

    logic fill;
    logic empty;
    logic unused_cmd_bits;

    assign fill            = cmd[6];
    assign empty           = cmd[1] | cmd[4];
    assign unused_cmd_bits = ^{cmd[5], cmd[2], cmd[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REPOUSO;
            rate_q  <= '0;
            nivel_q <= '0;
            ovf_q   <= '0;
            heat_q  <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            nivel_q <= nivel_d;
            ovf_q   <= ovf_d;
            heat_q  <= heat_d;
        end
    end

    // FALHA freezes everything; only reset can leave it.
    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        nivel_d = nivel_q;
        ovf_d   = ovf_q;
        heat_d  = heat_q;

        if (state_q != FALHA) begin
            ovf_d = (fill && nivel_q == 4'd15) ? ovf_q + 1'b1 : '0;

            if (fill && !empty) begin
                state_d = ENCHENDO;
            end else if (empty && !fill) begin
                state_d = ESVAZIANDO;
            end else begin
                state_d = REPOUSO;
            end
            if (ovf_d == OVF_LIM) begin
                state_d = FALHA;
            end

            if (cmd[3] && nivel_q >= LOW_L) begin
                heat_d = (heat_q == 4'd15) ? heat_q : heat_q + 4'd1;
            end else begin
                heat_d = (heat_q == 4'd0) ? heat_q : heat_q - 4'd1;
            end

            // A direction change discards any partial count.
            if (state_d != state_q) begin
                rate_d = '0;
            end else begin
                case (state_q)
                    ENCHENDO: begin
                        if (rate_q == FILL_LAST) begin
                            rate_d  = '0;
                            nivel_d = (nivel_q == 4'd15) ? nivel_q : nivel_q + 4'd1;
                        end else begin
                            rate_d = rate_q + 1'b1;
                        end
                    end
                    ESVAZIANDO: begin
                        if (rate_q == DRAIN_LAST) begin
                            rate_d  = '0;
                            nivel_d = (nivel_q == 4'd0) ? nivel_q : nivel_q - 4'd1;
                        end else begin
                            rate_d = rate_q + 1'b1;
                        end
                    end
                    default: rate_d = '0;
                endcase
            end
        end
    end

    assign nivel  = nivel_q;
    assign echeio = (nivel_q == 4'd15);
    assign sa     = (nivel_q >= LOW_L);
    assign se     = (nivel_q >= HIGH_L);
    assign temp   = (heat_q >= HEAT_L);
    assign alarme = (state_q == FALHA);

endmodule
